// File: rtl/cfu_op_sequencer.sv
// Single-command CFU sequencer: XOR, XOR-accumulate, accumulator read/clear and a
// multi-cycle popcount of A^B, with a valid/ready command and response channel.
module cfu_op_sequencer #(
    parameter int POP_BITS_PER_CYCLE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid & ready are both
    // high; the receiving side samples the payload only on that edge.
    localparam int NUM_CHUNKS = 32 / POP_BITS_PER_CYCLE;
    localparam int CNT_W      = 6;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_live;
    logic [31:0]      r_op_a;
    logic [31:0]      r_op_b;
    logic [31:0]      r_acc;
    logic [31:0]      r_result;
    logic [CNT_W-1:0] r_cnt;
    logic [5:0]       r_pop;

    logic             w_accept;
    logic [2:0]       w_opcode;
    logic             w_unused_fid;
    logic [31:0]      w_xor;
    logic [31:0]      w_chunk;
    logic [5:0]       w_chunk_ones;
    logic [5:0]       w_pop_sum;
    logic             w_last_chunk;

    // r_live keeps cmd_ready low until the first clk edge after reset is released.
    assign cmd_ready    = (r_state == ST_IDLE) && r_live;
    assign rsp_valid    = (r_state == ST_RESP);
    assign rsp_payload_outputs_0 = rsp_valid ? r_result : 32'd0;
    assign dbg_state    = r_state;

    assign w_accept     = cmd_valid && cmd_ready;
    assign w_opcode     = cmd_payload_function_id[2:0];
    assign w_unused_fid = &cmd_payload_function_id[9:3];
    assign w_xor        = r_op_a ^ r_op_b;
    assign w_chunk      = w_xor >> (32'(r_cnt) * POP_BITS_PER_CYCLE);
    assign w_pop_sum    = r_pop + w_chunk_ones;
    assign w_last_chunk = (r_cnt == LAST_CHUNK);

    always_comb begin
        w_chunk_ones = 6'd0;
        for (int i = 0; i < POP_BITS_PER_CYCLE; i++) begin
            w_chunk_ones = w_chunk_ones + 6'(w_chunk[i]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = (w_opcode == 3'd4) ? ST_BUSY : ST_RESP;
            ST_BUSY: if (w_last_chunk) w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_live   <= 1'b0;
            r_op_a   <= 32'd0;
            r_op_b   <= 32'd0;
            r_acc    <= 32'd0;
            r_result <= 32'd0;
            r_cnt    <= '0;
            r_pop    <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_op_a <= cmd_payload_inputs_0;
                r_op_b <= cmd_payload_inputs_1;
                r_cnt  <= '0;
                r_pop  <= 6'd0;
                case (w_opcode)
                    3'd0: r_result <= cmd_payload_inputs_0 ^ cmd_payload_inputs_1;
                    3'd1: begin
                        r_acc    <= r_acc ^ cmd_payload_inputs_0 ^ cmd_payload_inputs_1;
                        r_result <= r_acc ^ cmd_payload_inputs_0 ^ cmd_payload_inputs_1;
                    end
                    3'd2: r_result <= r_acc;
                    3'd3: begin
                        r_acc    <= 32'd0;
                        r_result <= r_acc;
                    end
                    default: r_result <= 32'd0;
                endcase
            end else if (r_state == ST_BUSY) begin
                // Chunks are consumed LSB first; the final sum lands in r_result on exit.
                r_pop <= w_pop_sum;
                if (w_last_chunk) begin
                    r_cnt    <= '0;
                    r_result <= {26'd0, w_pop_sum};
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/cfu_op_sequencer.md
CFU_OP_SEQUENCER -- requirements
Module: cfu_op_sequencer

Interface
REQ-001 Parameter POP_BITS_PER_CYCLE, default 4: operand bits the popcount unit consumes per cycle; legal values are 1, 2, 4, 8, 16 and 32.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  block accepts a command this cycle.
REQ-006 cmd_payload_function_id  input  10  opcode in bits [2:0]; bits [9:3] SHALL be ignored.
REQ-007 cmd_payload_inputs_0  input  32  operand A.
REQ-008 cmd_payload_inputs_1  input  32  operand B.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  consumer takes the response this cycle.
REQ-011 rsp_payload_outputs_0  output  32  response data.

Function
REQ-012 States: IDLE, BUSY, RESP; cmd_ready SHALL equal (state==IDLE); rsp_valid SHALL equal (state==RESP).
REQ-013 Command accept = cmd_valid & cmd_ready; opcode and operands SHALL be registered on accept.
REQ-014 Opcode 0 (XOR): result = A ^ B; IDLE->RESP on accept.
REQ-015 Opcode 1 (ACC): 32-bit acc <= acc ^ A ^ B; result = the new acc value; IDLE->RESP.
REQ-016 Opcode 2 (READ): result = acc; acc unchanged; IDLE->RESP.
REQ-017 Opcode 3 (CLEAR): acc <= 0; result = previous acc; IDLE->RESP.
REQ-018 Opcode 4 (POPCNT): IDLE->BUSY; the block SHALL count the ones in A ^ B, consuming POP_BITS_PER_CYCLE bits per cycle starting at the LSB chunk; the result is zero-extended to 32 bits (range 0..32).
REQ-019 BUSY SHALL last exactly 32/POP_BITS_PER_CYCLE cycles, then go to RESP; the chunk counter SHALL wrap to 0 on exit.
REQ-020 Opcodes 5-7: result = 0; acc unchanged; IDLE->RESP.
REQ-021 Latency from the accept edge to rsp_valid high: 1 cycle for opcodes 0-3 and 5-7; 1 + 32/POP_BITS_PER_CYCLE cycles for opcode 4 (9 cycles at default).
REQ-022 In RESP, rsp_payload_outputs_0 SHALL remain stable until rsp_valid & rsp_ready; on that handshake the state SHALL go RESP->IDLE.
REQ-023 No bypass: cmd_ready SHALL be low in the handshake cycle and rise the following cycle, so the sustained rate is at most one command every 2 cycles.
REQ-024 cmd_valid while cmd_ready is low SHALL have no effect; operands may change freely while the block is busy.
REQ-025 rsp_payload_outputs_0 SHALL read 0 whenever rsp_valid is low.
REQ-026 acc SHALL change only on ACC, CLEAR or reset.

Reset
REQ-027 On reset assertion, regardless of clk: state=IDLE, acc=0, popcount count/counter=0, rsp_valid=0, rsp_payload_outputs_0=0.
REQ-028 While reset is high, cmd_ready SHALL be 0; it SHALL rise to 1 on the first clk edge after deassertion.
REQ-029 Reset during BUSY or RESP SHALL abort the operation with no response emitted; the next accepted command SHALL behave as after power-up.

Verification
REQ-030 XOR: A=0xFFFF0000, B=0x0F0F0F0F, opcode 0, rsp_ready=1 -> rsp_valid 1 cycle after accept, data 0xF0F00F0F; cmd_ready high 2 cycles after accept.
REQ-031 ACC chain: ACC(0x1,0x2), ACC(0x4,0x0), READ -> responses 0x3, 0x7, 0x7; CLEAR -> 0x7; READ -> 0x0.
REQ-032 POPCNT at default parameter: A=0xFFFFFFFF, B=0x00000000 -> 32 after 9 cycles; A=B=0x12345678 -> 0; A=0x80000001, B=0 -> 2.
REQ-033 Backpressure: rsp_ready=0 for 5 cycles after XOR(0xA,0x5) completes -> rsp_valid held, data stable at 0xF, cmd_ready low; a concurrent cmd_valid is ignored and acc is unchanged.
REQ-034 Reset mid-POPCNT: assert reset 3 cycles after accepting POPCNT(0xFFFFFFFF,0) -> rsp_valid never rises, acc=0; a following READ returns 0x0.
REQ-035 Opcode 7 with function_id=0x3FF -> data 0x0; acc unchanged, confirmed by a following READ.
